// File: rtl/board_line_clear.sv
// Playfield store and line-clear engine: writes locked pieces, collapses full rows one row per
// cycle, and serves combinational cell reads and four-cell placement probes.
module board_line_clear #(
   parameter int BOARD_W = 10,
   parameter int BOARD_H = 20
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        lock_valid,
   input  logic [19:0] lock_x,
   input  logic [19:0] lock_y,
   input  logic [2:0]  lock_color,
   input  logic        clear_board,
   input  logic [19:0] probe_x,
   input  logic [19:0] probe_y,
   output logic        probe_free,
   input  logic [4:0]  rd_x,
   input  logic [4:0]  rd_y,
   output logic [2:0]  rd_color,
   output logic        busy,
   output logic        done,
   output logic [2:0]  lines_cleared,
   output logic [15:0] total_lines,
   output logic        game_over
);

   localparam int XW = $clog2(BOARD_W);
   localparam int YW = $clog2(BOARD_H);
   localparam logic [4:0] W_LIM    = 5'(BOARD_W);
   localparam logic [4:0] H_LIM    = 5'(BOARD_H);
   localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);

   typedef logic [BOARD_W-1:0][2:0] row_t;
   typedef row_t [BOARD_H-1:0]      board_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_SCAN  = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4,
      S_WIPE  = 3'd5
   } state_t;

   function automatic logic in_range(input logic [4:0] x, input logic [4:0] y);
      return (x < W_LIM) && (y < H_LIM);
   endfunction

   // Out-of-range coordinates read as EMPTY so 5-bit wrap-around can never alias a real cell.
   function automatic logic [2:0] cell_at(input board_t b, input logic [4:0] x, input logic [4:0] y);
      logic [2:0] c;
      if (in_range(x, y)) begin
         c = b[y[YW-1:0]][x[XW-1:0]];
      end else begin
         c = 3'd0;
      end
      return c;
   endfunction

   function automatic logic row_full(input row_t row);
      logic f;
      f = 1'b1;
      for (int i = 0; i < BOARD_W; i++) f = f & (row[i] != 3'd0);
      return f;
   endfunction

   function automatic logic row_any(input row_t row);
      logic a;
      a = 1'b0;
      for (int i = 0; i < BOARD_W; i++) a = a | (row[i] != 3'd0);
      return a;
   endfunction

   state_t      state_q, state_d;
   board_t      board_q, board_d;
   logic [4:0]  r_q, r_d, k_q, k_d;
   logic [2:0]  n_q, n_d;
   logic [19:0] lx_q, lx_d, ly_q, ly_d;
   logic [2:0]  lc_q, lc_d;
   logic        busy_q, busy_d, done_q, done_d, go_q, go_d;
   logic [2:0]  lines_q, lines_d;
   logic [15:0] total_q, total_d;
   logic        hit_s;

   assign rd_color      = cell_at(board_q, rd_x, rd_y);
   assign busy          = busy_q;
   assign done          = done_q;
   assign lines_cleared = lines_q;
   assign total_lines   = total_q;
   assign game_over     = go_q;

   // Probe is free only if every candidate cell lies on the board and is empty.
   always_comb begin
      probe_free = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (!in_range(probe_x[5*i +: 5], probe_y[5*i +: 5]) ||
             (cell_at(board_q, probe_x[5*i +: 5], probe_y[5*i +: 5]) != 3'd0)) begin
            probe_free = 1'b0;
         end else begin
            probe_free = probe_free;
         end
      end
   end

   // Next-state, board update and result bookkeeping.
   always_comb begin
      state_d = state_q;
      board_d = board_q;
      r_d     = r_q;
      k_d     = k_q;
      n_d     = n_q;
      lx_d    = lx_q;
      ly_d    = ly_q;
      lc_d    = lc_q;
      done_d  = 1'b0;
      lines_d = lines_q;
      total_d = total_q;
      go_d    = go_q;
      hit_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (lock_valid) begin
               state_d = S_WRITE;
               lx_d    = lock_x;
               ly_d    = lock_y;
               lc_d    = lock_color;
               n_d     = 3'd0;
            end else if (clear_board) begin
               state_d = S_WIPE;
               r_d     = 5'd0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            // Cells outside the board never match a loop coordinate, so they drop out here.
            for (int yy = 0; yy < BOARD_H; yy++) begin
               for (int xx = 0; xx < BOARD_W; xx++) begin
                  hit_s = 1'b0;
                  for (int i = 0; i < 4; i++) begin
                     hit_s = hit_s | ((lx_q[5*i +: 5] == 5'(xx)) && (ly_q[5*i +: 5] == 5'(yy)));
                  end
                  board_d[yy][xx] = hit_s ? lc_q : board_q[yy][xx];
               end
            end
            r_d     = LAST_ROW;
            state_d = S_SCAN;
         end
         S_SCAN: begin
            if (row_full(board_q[r_q[YW-1:0]])) begin
               state_d = S_SHIFT;
               k_d     = r_q;
               n_d     = (n_q == 3'd7) ? n_q : n_q + 3'd1;
            end else if (r_q == 5'd0) begin
               state_d = S_DONE;
            end else begin
               r_d     = r_q - 5'd1;
               state_d = S_SCAN;
            end
         end
         S_SHIFT: begin
            // Rescan the same r afterwards: the row that dropped into it may also be full.
            if (k_q == 5'd0) begin
               board_d[0] = '0;
               state_d    = S_SCAN;
            end else begin
               for (int yy = 1; yy < BOARD_H; yy++) begin
                  board_d[yy] = (5'(yy) == k_q) ? board_q[yy-1] : board_q[yy];
               end
               k_d     = k_q - 5'd1;
               state_d = S_SHIFT;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            lines_d = n_q;
            total_d = total_q + {13'd0, n_q};
            go_d    = go_q | row_any(board_q[0]);
            state_d = S_IDLE;
         end
         S_WIPE: begin
            for (int yy = 0; yy < BOARD_H; yy++) begin
               board_d[yy] = (5'(yy) == r_q) ? row_t'('0) : board_q[yy];
            end
            if (r_q == LAST_ROW) begin
               go_d    = 1'b0;
               state_d = S_IDLE;
            end else begin
               r_d     = r_q + 5'd1;
               state_d = S_WIPE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and storage registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         board_q <= '0;
         r_q     <= 5'd0;
         k_q     <= 5'd0;
         n_q     <= 3'd0;
         lx_q    <= 20'd0;
         ly_q    <= 20'd0;
         lc_q    <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lines_q <= 3'd0;
         total_q <= 16'd0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         board_q <= board_d;
         r_q     <= r_d;
         k_q     <= k_d;
         n_q     <= n_d;
         lx_q    <= lx_d;
         ly_q    <= ly_d;
         lc_q    <= lc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lines_q <= lines_d;
         total_q <= total_d;
         go_q    <= go_d;
      end
   end

endmodule
